// File: rtl/pic_inta_sequencer_pkg.sv
// Shared types and constants for the PIC INTA sequencer and its priority resolver.
package pic_inta_sequencer_pkg;

    localparam int unsigned NUM_IR = 8;
    localparam logic [2:0] SPURIOUS_LVL = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEND,
        ST_ACK1,
        ST_WAIT2,
        ST_ACK2
    } state_t;

    // Index of the lowest set bit (highest priority); 0 when nothing is set.
    function automatic logic [2:0] lowest_index(input logic [NUM_IR-1:0] v);
        logic [2:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_IR; i++) begin
            if (v[i] && !found) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pic_inta_sequencer_if.sv
// Request, acknowledge, EOI and vector signals between the PIC core and the sequencer.
interface pic_inta_sequencer_if;

    logic [7:0] irr_in;
    logic [7:0] imr;
    logic       inta_n;
    logic       eoi;
    logic       seoi;
    logic [2:0] seoi_level;
    logic [4:0] vector_base;
    logic       int_out;
    logic [7:0] irr_clear;
    logic [7:0] isr;
    logic [7:0] vector;
    logic       vector_valid;

    modport slave (
        input  irr_in, imr, inta_n, eoi, seoi, seoi_level, vector_base,
        output int_out, irr_clear, isr, vector, vector_valid
    );

    modport master (
        output irr_in, imr, inta_n, eoi, seoi, seoi_level, vector_base,
        input  int_out, irr_clear, isr, vector, vector_valid
    );

endinterface

// File: rtl/pic_inta_sequencer_resolver.sv
// Fixed-priority resolver: unmasked requests above the highest in-service level, lowest index wins.
module pic_priority_resolver
    import pic_inta_sequencer_pkg::*;
(
    input  logic [7:0] irr_in,
    input  logic [7:0] imr,
    input  logic [7:0] isr,
    output logic       eligible_any,
    output logic [2:0] winner
);

    logic [7:0] limit;
    logic [7:0] eligible;

    always_comb begin
        limit = '1;
        // Only levels strictly below the lowest in-service index may nest.
        if (isr != '0) begin
            limit = (8'(1) << lowest_index(isr)) - 8'(1);
        end
        eligible     = irr_in & ~imr & limit;
        eligible_any = |eligible;
        winner       = lowest_index(eligible);
    end

endmodule

// File: rtl/pic_inta_sequencer.sv
// 8259-style INTA sequencer: raises INT, runs the two-pulse acknowledge, owns ISR and EOI handling.
module pic_inta_sequencer
    import pic_inta_sequencer_pkg::*;
#(
    parameter logic AEOI = 1'b0
)
(
    input  logic                        clk,
    input  logic                        rst,
    pic_inta_sequencer_if.slave         bus
);

    state_t     state;
    logic       inta_q;
    logic [2:0] level;
    logic       spurious;
    logic [7:0] isr_q;
    logic       int_q;
    logic [7:0] irr_clear_q;
    logic [7:0] vector_q;
    logic       vector_valid_q;

    logic       eligible_any;
    logic [2:0] winner;
    logic       inta_fall;
    logic       inta_rise;
    logic [7:0] eoi_clr;
    logic [7:0] aeoi_clr;
    logic [7:0] isr_set;

    pic_priority_resolver u_resolver (
        .irr_in       (bus.irr_in),
        .imr          (bus.imr),
        .isr          (isr_q),
        .eligible_any (eligible_any),
        .winner       (winner)
    );

    always_comb begin
        inta_fall = inta_q & ~bus.inta_n;
        inta_rise = ~inta_q & bus.inta_n;

        // EOI masks are derived from the pre-set ISR; a same-cycle set is OR-ed in last so it wins.
        eoi_clr = '0;
        if (bus.seoi) begin
            eoi_clr = 8'(1) << bus.seoi_level;
        end else if (bus.eoi && isr_q != '0) begin
            eoi_clr = 8'(1) << lowest_index(isr_q);
        end

        isr_set = '0;
        if (state == ST_PEND && inta_fall && eligible_any) begin
            isr_set = 8'(1) << winner;
        end

        aeoi_clr = '0;
        if (AEOI && state == ST_ACK2 && inta_rise && !spurious) begin
            aeoi_clr = 8'(1) << level;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            inta_q         <= 1'b1;
            level          <= '0;
            spurious       <= 1'b0;
            isr_q          <= '0;
            int_q          <= 1'b0;
            irr_clear_q    <= '0;
            vector_q       <= '0;
            vector_valid_q <= 1'b0;
        end else begin
            inta_q      <= bus.inta_n;
            irr_clear_q <= '0;
            isr_q       <= (isr_q & ~eoi_clr & ~aeoi_clr) | isr_set;

            case (state)
                ST_IDLE: begin
                    if (eligible_any) begin
                        state <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (inta_fall) begin
                        level       <= eligible_any ? winner : SPURIOUS_LVL;
                        spurious    <= ~eligible_any;
                        irr_clear_q <= isr_set;
                        int_q       <= 1'b0;
                        state       <= ST_ACK1;
                    end else begin
                        int_q <= 1'b1;
                    end
                end
                ST_ACK1: begin
                    if (inta_rise) begin
                        state <= ST_WAIT2;
                    end
                end
                ST_WAIT2: begin
                    if (inta_fall) begin
                        vector_valid_q <= 1'b1;
                        vector_q       <= {bus.vector_base, level};
                        state          <= ST_ACK2;
                    end
                end
                ST_ACK2: begin
                    if (inta_rise) begin
                        vector_valid_q <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.int_out      = int_q;
    assign bus.irr_clear    = irr_clear_q;
    assign bus.isr          = isr_q;
    assign bus.vector       = vector_q;
    assign bus.vector_valid = vector_valid_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Self-checking bench: directed scenarios plus randomized acknowledge/EOI traffic against a transaction-level model.
module tb_pic_inta_sequencer;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    logic [7:0] m_isr;
    logic [7:0] pend;

    pic_inta_sequencer_if b0();
    pic_inta_sequencer_if b1();

    pic_inta_sequencer #(.AEOI(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    pic_inta_sequencer #(.AEOI(1'b1)) dut_aeoi (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Reference: the highest-priority unmasked request above every in-service level, or -1.
    function automatic int model_winner(input logic [7:0] irr, input logic [7:0] imr, input logic [7:0] isr);
        int top;
        top = 8;
        for (int i = 0; i < 8; i++) begin
            if (isr[i]) begin
                top = i;
                break;
            end
        end
        for (int i = 0; i < top; i++) begin
            if (irr[i] && !imr[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_eoi(input logic [7:0] s, input bit e, input bit se, input logic [2:0] lvl);
        logic [7:0] r;
        r = s;
        if (se) begin
            r[lvl] = 1'b0;
        end else if (e) begin
            for (int i = 0; i < 8; i++) begin
                if (r[i]) begin
                    r[i] = 1'b0;
                    break;
                end
            end
        end
        return r;
    endfunction

    task automatic pulse_eoi(input bit e, input bit se, input logic [2:0] lvl);
        b0.eoi        = e;
        b0.seoi       = se;
        b0.seoi_level = lvl;
        tick();
        b0.eoi  = 1'b0;
        b0.seoi = 1'b0;
        m_isr   = model_eoi(m_isr, e, se, lvl);
        check("eoi isr", b0.isr, m_isr);
    endtask

    task automatic wait_int(input string tag);
        int n;
        n = 0;
        while (b0.int_out !== 1'b1 && n < 6) begin
            tick();
            n++;
        end
        check(tag, {7'd0, b0.int_out}, 8'h01);
    endtask

    // Full two-pulse acknowledge on b0; an EOI may be folded into the first falling edge.
    task automatic do_ack(input bit e, input bit se, input logic [2:0] lvl);
        int         w;
        logic [7:0] exp_clr;
        logic [2:0] vlvl;
        w       = model_winner(b0.irr_in, b0.imr, m_isr);
        exp_clr = (w >= 0) ? 8'(1) << w : 8'h00;
        vlvl    = (w >= 0) ? 3'(w) : 3'd7;

        b0.inta_n     = 1'b0;
        b0.eoi        = e;
        b0.seoi       = se;
        b0.seoi_level = lvl;
        tick();
        b0.eoi  = 1'b0;
        b0.seoi = 1'b0;
        m_isr   = model_eoi(m_isr, e, se, lvl) | exp_clr;
        check("ack1 irr_clear", b0.irr_clear, exp_clr);
        check("ack1 isr", b0.isr, m_isr);
        check("ack1 int_out", {7'd0, b0.int_out}, 8'h00);
        b0.irr_in = b0.irr_in & ~exp_clr;
        pend      = pend & ~exp_clr;
        tick();
        check("irr_clear width", b0.irr_clear, 8'h00);
        b0.inta_n = 1'b1;
        tick();
        check("ack1 vv", {7'd0, b0.vector_valid}, 8'h00);
        b0.inta_n = 1'b0;
        tick();
        check("ack2 vv", {7'd0, b0.vector_valid}, 8'h01);
        check("ack2 vector", b0.vector, {b0.vector_base, vlvl});
        tick();
        check("ack2 vv hold", {7'd0, b0.vector_valid}, 8'h01);
        b0.inta_n = 1'b1;
        b0.irr_in = 8'h00;
        tick();
        check("ack2 vv end", {7'd0, b0.vector_valid}, 8'h00);
        check("ack2 isr", b0.isr, m_isr);
    endtask

    initial begin
        int         w;
        int unsigned r;
        n_checks = 0;
        n_fail   = 0;
        m_isr    = 8'h00;
        pend     = 8'h00;
        rst      = 1'b1;
        b0.irr_in = 8'h00; b0.imr = 8'h00; b0.inta_n = 1'b1; b0.eoi = 1'b0;
        b0.seoi = 1'b0; b0.seoi_level = 3'd0; b0.vector_base = 5'h08;
        b1.irr_in = 8'h00; b1.imr = 8'h00; b1.inta_n = 1'b1; b1.eoi = 1'b0;
        b1.seoi = 1'b0; b1.seoi_level = 3'd0; b1.vector_base = 5'h11;
        tick();
        tick();
        check("rst isr", b0.isr, 8'h00);
        check("rst int_out", {7'd0, b0.int_out}, 8'h00);
        check("rst irr_clear", b0.irr_clear, 8'h00);
        check("rst vector", b0.vector, 8'h00);
        check("rst vv", {7'd0, b0.vector_valid}, 8'h00);
        rst = 1'b0;
        tick();

        // Basic acknowledge with exact request-to-INT latency.
        b0.irr_in = 8'h24;
        tick();
        check("lat1 int_out", {7'd0, b0.int_out}, 8'h00);
        tick();
        check("lat2 int_out", {7'd0, b0.int_out}, 8'h01);
        do_ack(1'b0, 1'b0, 3'd0);
        check("basic vector", b0.vector, 8'h42);
        pulse_eoi(1'b1, 1'b0, 3'd0);

        // Nesting: IR1 preempts IR5; IR6 stays blocked until IR5 retires.
        b0.irr_in = 8'h20;
        wait_int("nest ir5 int");
        do_ack(1'b0, 1'b0, 3'd0);
        b0.irr_in = 8'h22;
        wait_int("nest ir1 int");
        do_ack(1'b0, 1'b0, 3'd0);
        check("nest isr", b0.isr, 8'h22);
        pulse_eoi(1'b1, 1'b0, 3'd0);
        b0.irr_in = 8'h40;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("nest blocked", {7'd0, b0.int_out}, 8'h00);
        end
        pulse_eoi(1'b0, 1'b1, 3'd5);
        wait_int("nest ir6 int");
        do_ack(1'b0, 1'b0, 3'd0);
        pulse_eoi(1'b1, 1'b1, 3'd6);

        // Masked request never raises INT.
        b0.imr    = 8'h01;
        b0.irr_in = 8'h01;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("masked int_out", {7'd0, b0.int_out}, 8'h00);
        end
        b0.imr    = 8'h00;
        b0.irr_in = 8'h00;
        tick();

        // Withdrawal during PEND takes the spurious path.
        b0.irr_in = 8'h08;
        wait_int("wd int");
        b0.irr_in = 8'h00;
        tick();
        tick();
        check("wd int hold", {7'd0, b0.int_out}, 8'h01);
        do_ack(1'b0, 1'b0, 3'd0);
        check("wd vector", b0.vector, 8'h47);

        // EOI folded into the ISR-setting edge acts on the pre-set value.
        b0.irr_in = 8'h10;
        wait_int("fold ir4 int");
        do_ack(1'b0, 1'b0, 3'd0);
        b0.irr_in = 8'h02;
        wait_int("fold ir1 int");
        do_ack(1'b1, 1'b0, 3'd0);
        check("fold isr", b0.isr, 8'h02);
        pulse_eoi(1'b0, 1'b1, 3'd1);

        // Automatic EOI on the second instance.
        b1.irr_in = 8'h08;
        tick();
        tick();
        check("aeoi int", {7'd0, b1.int_out}, 8'h01);
        b1.inta_n = 1'b0;
        tick();
        check("aeoi irr_clear", b1.irr_clear, 8'h08);
        check("aeoi isr set", b1.isr, 8'h08);
        b1.irr_in = 8'h00;
        b1.inta_n = 1'b1;
        tick();
        b1.inta_n = 1'b0;
        tick();
        check("aeoi vector", b1.vector, 8'h8b);
        check("aeoi isr held", b1.isr, 8'h08);
        b1.inta_n = 1'b1;
        tick();
        check("aeoi vv end", {7'd0, b1.vector_valid}, 8'h00);
        check("aeoi isr clr", b1.isr, 8'h00);

        // Reset in WAIT2, then a stray INTA pulse must be ignored.
        b0.irr_in = 8'h10;
        wait_int("rstw int");
        b0.inta_n = 1'b0;
        tick();
        check("rstw irr_clear", b0.irr_clear, 8'h10);
        b0.irr_in = 8'h00;
        b0.inta_n = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        m_isr = 8'h00;
        pend  = 8'h00;
        check("rstw isr", b0.isr, 8'h00);
        check("rstw int_out", {7'd0, b0.int_out}, 8'h00);
        check("rstw vector", b0.vector, 8'h00);
        check("rstw vv", {7'd0, b0.vector_valid}, 8'h00);
        b0.inta_n = 1'b0;
        tick();
        check("stray vv1", {7'd0, b0.vector_valid}, 8'h00);
        tick();
        b0.inta_n = 1'b1;
        tick();
        check("stray vv2", {7'd0, b0.vector_valid}, 8'h00);
        check("stray isr", b0.isr, 8'h00);

        // Randomized traffic against the model.
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 3);
            if (r != 0) pulse_eoi(r[0], r[1], 3'($urandom_range(0, 7)));
            pend           = pend | (8'($urandom) & 8'($urandom));
            b0.imr         = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            b0.vector_base = 5'($urandom);
            b0.irr_in      = pend;
            w = model_winner(pend, b0.imr, m_isr);
            tick();
            check("rnd lat1", {7'd0, b0.int_out}, 8'h00);
            tick();
            check("rnd lat2", {7'd0, b0.int_out}, (w >= 0) ? 8'h01 : 8'h00);
            if (w >= 0) begin
                r = $urandom_range(0, 5);
                do_ack(r == 1, r == 2, 3'($urandom_range(0, 7)));
            end else begin
                b0.irr_in = 8'h00;
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
